// File: rtl/fsm_button_conditioner_if.sv
// fsm_button_conditioner_if: raw pushbutton inputs and conditioned FSM controls
//   key_pause_n   raw pause pushbutton, active-low, asynchronous
//   key_restart_n raw restart pushbutton, active-low, asynchronous
//   pause         registered pause level
//   restart       registered one-cycle restart pulse
interface fsm_button_conditioner_if;
    logic key_pause_n;
    logic key_restart_n;
    logic pause;
    logic restart;
    modport master (output key_pause_n, key_restart_n, input pause, restart);
    modport slave (input key_pause_n, key_restart_n, output pause, restart);
endinterface

// File: rtl/fsm_button_conditioner.sv
// fsm_button_conditioner: synchronise and debounce two pushbuttons into pause/restart controls
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  slave side: key_pause_n/key_restart_n in, pause/restart out
module fsm_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit PAUSE_TOGGLE    = 1'b1
) (
    input logic                     clk,
    input logic                     rst,
    fsm_button_conditioner_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    // bit 0 = pause channel, bit 1 = restart channel
    logic [1:0] key, s1, s2, db, hit, press, db_nxt;
    logic [CW-1:0] cnt [2];
    logic pause_q, restart_q;
    assign key = ~{bus.key_restart_n, bus.key_pause_n};
    always_comb begin
        hit = '0;
        for (int c = 0; c < 2; c++) hit[c] = (s2[c] != db[c]) && (cnt[c] == LAST);
        press  = hit & s2;
        db_nxt = db ^ hit;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            db        <= '0;
            for (int c = 0; c < 2; c++) cnt[c] <= '0;
            pause_q   <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            s1        <= key;
            s2        <= s1;
            db        <= db_nxt;
            // any sample matching db breaks the run, so bounces never accumulate
            for (int c = 0; c < 2; c++) cnt[c] <= (s2[c] == db[c] || hit[c]) ? '0 : cnt[c] + 1'b1;
            restart_q <= press[1];
            // a restart press takes priority over a simultaneous pause press
            pause_q   <= PAUSE_TOGGLE ? (!press[1] && (pause_q ^ press[0])) : db_nxt[0];
        end
    end
    assign bus.pause   = pause_q;
    assign bus.restart = restart_q;
endmodule

// File: tb/tb_fsm_button_conditioner.sv
// tb_fsm_button_conditioner: randomized and directed check of both pause modes against a reference model
module tb_fsm_button_conditioner;
    localparam int DC = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic kp_n = 1'b1;
    logic kr_n = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    fsm_button_conditioner_if bt ();
    fsm_button_conditioner_if bl ();
    assign bt.key_pause_n   = kp_n;
    assign bt.key_restart_n = kr_n;
    assign bl.key_pause_n   = kp_n;
    assign bl.key_restart_n = kr_n;
    fsm_button_conditioner #(.DEBOUNCE_CYCLES(DC), .PAUSE_TOGGLE(1'b1)) dut_t (.clk(clk), .rst(rst), .bus(bt.slave));
    fsm_button_conditioner #(.DEBOUNCE_CYCLES(DC), .PAUSE_TOGGLE(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bl.slave));
    // reference: a key value must arrive two edges late and persist for DC
    // consecutive samples away from the stable value before it is accepted
    bit d1 [2], d2 [2], mdb [2];
    bit win [2][$];
    bit m_restart, m_pt, m_pl;
    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask
    task automatic model();
        bit k [2];
        bit ev [2];
        k[0] = !kp_n;
        k[1] = !kr_n;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                d1[c] = 0; d2[c] = 0; mdb[c] = 0; win[c].delete();
            end
            m_restart = 0; m_pt = 0; m_pl = 0;
            return;
        end
        for (int c = 0; c < 2; c++) begin
            bit all_diff;
            ev[c] = 0;
            win[c].push_back(d2[c]);
            if (win[c].size() > DC) void'(win[c].pop_front());
            all_diff = (win[c].size() == DC);
            foreach (win[c][j]) if (win[c][j] == mdb[c]) all_diff = 0;
            if (all_diff) begin
                mdb[c] = !mdb[c];
                ev[c] = mdb[c];
                win[c].delete();
            end
            d2[c] = d1[c];
            d1[c] = k[c];
        end
        m_restart = ev[1];
        m_pt = ev[1] ? 1'b0 : (m_pt ^ ev[0]);
        m_pl = mdb[0];
    endtask
    task automatic tick();
        @(posedge clk);
        model();
        #1;
        check("restart", int'(bt.restart), int'(m_restart));
        check("pause_toggle", int'(bt.pause), int'(m_pt));
        check("pause_level", int'(bl.pause), int'(m_pl));
        check("restart_level", int'(bl.restart), int'(m_restart));
    endtask
    task automatic idle(input int n);
        kp_n = 1; kr_n = 1;
        repeat (n) tick();
    endtask
    initial begin
        int first, pulses;
        bit pat [6] = '{0, 1, 0, 0, 1, 0};
        repeat (3) tick();
        check("reset_pause", int'(bt.pause), 0);
        check("reset_restart", int'(bt.restart), 0);
        rst = 0;
        idle(4);
        // clean restart press: single pulse after edge 6
        kr_n = 0; first = -1; pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bt.restart) begin pulses++; if (first < 0) first = i; end
        end
        kr_n = 1;
        for (int i = 0; i < 12; i++) begin tick(); if (bt.restart) pulses++; end
        check("clean_latency", first, 6);
        check("clean_pulses", pulses, 1);
        check("clean_pause", int'(bt.pause), 0);
        // bounce then held press; then a short glitch
        foreach (pat[i]) begin kp_n = pat[i]; tick(); end
        kp_n = 0;
        repeat (12) tick();
        check("bounce_pause", int'(bt.pause), 1);
        idle(12);
        kp_n = 0; repeat (3) tick();
        idle(12);
        check("glitch_pause", int'(bt.pause), 1);
        // two clean toggles
        repeat (2) begin kp_n = 0; repeat (10) tick(); idle(10); end
        check("toggle_pause", int'(bt.pause), 1);
        // simultaneous press: restart wins on edge 6
        check("pre_pause", int'(bt.pause), 1);
        kp_n = 0; kr_n = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 5) check("sim_pause_before", int'(bt.pause), 1);
            if (i == 6) begin
                check("sim_restart", int'(bt.restart), 1);
                check("sim_pause", int'(bt.pause), 0);
            end
        end
        idle(12);
        // level mode follows a 12-cycle press
        kp_n = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 5) check("level_before", int'(bl.pause), 0);
            if (i == 6) check("level_set", int'(bl.pause), 1);
        end
        kp_n = 1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 5) check("level_hold", int'(bl.pause), 1);
            if (i == 6) check("level_clear", int'(bl.pause), 0);
        end
        idle(6);
        // reset mid-count with key held
        kr_n = 0;
        repeat (3) tick();
        rst = 1; tick(); rst = 0;
        check("rst_restart", int'(bt.restart), 0);
        check("rst_pause", int'(bt.pause), 0);
        first = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (bt.restart && first < 0) first = i;
        end
        check("rst_latency", first, 6);
        idle(12);
        // random keys with occasional reset
        for (int i = 0; i < 400; i++) begin
            kp_n = 1'($urandom_range(0, 1));
            kr_n = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            rst  = ($urandom_range(0, 40) == 0);
            repeat ($urandom_range(1, 12)) tick();
            rst = 0;
        end
        idle(12);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fsm_button_conditioner.md
# fsm_button_conditioner

Input conditioning stage that sits directly upstream of the pause/restart sequencing FSM. It takes two raw, asynchronous, active-low board pushbuttons and synchronises and debounces them. It then delivers a clean `pause` level and a single-cycle `restart` pulse on the `clk` domain, ready to drive the FSM's `pause` and `restart` inputs unmodified.

## Interface
- `DEBOUNCE_CYCLES`, default 16 — consecutive cycles a synchronised key must differ from its debounced value before the debounced value changes; legal range ≥ 2.
- `PAUSE_TOGGLE`, default 1 — 1: each debounced press of the pause key toggles `pause`; 0: `pause` follows the debounced pause key level.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `key_pause_n`  in  1  raw pause pushbutton, active-low, asynchronous to `clk`.
- `key_restart_n`  in  1  raw restart pushbutton, active-low, asynchronous to `clk`.
- `pause`  out  1  registered pause level to the FSM.
- `restart`  out  1  registered one-cycle restart pulse to the FSM.

## Operation
- Each channel (pause, restart) is processed identically through the following chain:
  - Invert the key to active-high.
  - Pass it through a 2-flop synchroniser (`s1` → `s2`).
  - Debounce it into a stable bit `db` using a counter `cnt`.
- Counter width: `max(1, $clog2(DEBOUNCE_CYCLES))`; `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap.
- Debounce rule, every edge, per channel:
  - `s2 == db`: `cnt <= 0`.
  - `s2 != db` and `cnt == DEBOUNCE_CYCLES-1`: `db <= s2`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt + 1`.
- Press event: the edge on which the debounce rule updates `db` from 0 to 1. Release event: the same for 1 to 0.
- `restart` is 1 for exactly the one cycle following a restart press event, and 0 otherwise. A held key produces one pulse only; a release produces no pulse.
- Pause in toggle mode (`PAUSE_TOGGLE=1`):
  - A pause press event inverts `pause`; release events are ignored.
  - A restart press event forces `pause <= 0`. If a pause press and a restart press occur on the same edge, the restart wins: `pause <= 0` and `restart` pulses.
- Pause in level mode (`PAUSE_TOGGLE=0`): `pause <= db` of the pause channel, and it is unaffected by restart.
- Bounce or glitch: any excursion of `s2` shorter than `DEBOUNCE_CYCLES` cycles resets `cnt` and has no effect on `db` or the outputs.
- Reset values, applied synchronously: all `s1`, `s2`, `db`, `cnt` = 0 (key released); `pause` = 0; `restart` = 0.
  - `rst` overrides all other activity on the same edge.
  - `rst` asserted mid-count discards the partial count.
  - A key held through reset is treated as a new press once `rst` deasserts and the full debounce interval has elapsed.

## Timing
- Edge numbering: edge 1 is the first rising edge at which the raw key is sampled low with `rst` = 0 (key stable thereafter).
- `s2` reflects the press after edge 2.
- `cnt` counts on edges 3 … `DEBOUNCE_CYCLES+1`.
- `db` sets on edge `DEBOUNCE_CYCLES+2`. `restart` is high, or `pause` toggles, from that same edge.
  - `restart` drops at the next edge.
- Press-to-output latency: `DEBOUNCE_CYCLES+2` cycles (18 at default). Release latency is identical.
- Minimum press width seen: `DEBOUNCE_CYCLES` synchronised cycles.
- Minimum spacing between two recognised presses on one channel: `2*DEBOUNCE_CYCLES` cycles (press plus release).
- Both outputs are driven directly from flops; no combinational path from keys to outputs.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `PAUSE_TOGGLE=1` unless stated.
- Clean press: hold `key_restart_n`=0 from edge 1 for 20 cycles → `restart`=1 only after edge 6, for 1 cycle; `pause` stays 0; no second pulse while held or on release.
- Bounce: `key_pause_n` pattern 0,1,0,0,1,0 (one value per cycle), then held 0 → no output change during the bounce; `pause` toggles to 1 exactly 6 edges after the final stable 0 is first sampled. A 3-cycle low glitch → no change.
- Toggle: two separate clean pause presses, each held 10 cycles, 10-cycle gap → `pause` 0→1 after the first press, 1→0 after the second.
- Simultaneous events:
  - Set `pause`=1.
  - Press both keys on the same edge → on edge 6 `restart`=1 and `pause`=0 together.
- Level mode (`PAUSE_TOGGLE=0`): hold `key_pause_n`=0 for 12 cycles → `pause`=1 from edge 6 until 6 edges after release.
- Reset: assert `rst` for 1 cycle mid-count (edge 4 of a restart press) → `restart` and `pause` are 0 on the next cycle; with the key still held, `restart` pulses 6 edges after `rst` deasserts.
